alp_qdreg: RTL and testbench
============================

ALP_QDREG -- requirements
Module: alp_qdreg

Interface
REQ-001 SHALL provide: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL provide: rst_l  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide: qmux_onehot_h  input  4  Q source select {wmux, shl, shr, amux}, bit 3 down to bit 0, from the DQ decoder.
REQ-004 SHALL provide: qreg_en_h  input  1  Q register write enable.
REQ-005 SHALL provide: dreg_en_h  input  1  D register write enable.
REQ-006 SHALL provide: wmux_h  input  4  W mux data.
REQ-007 SHALL provide: amux_h  input  4  A mux data.
REQ-008 SHALL provide: dbus_h  input  4  D register load data.
REQ-009 SHALL provide: qshl_in_h  input  1  shift-in to Q bit 0 on left shift, from the lower slice.
REQ-010 SHALL provide: qshr_in_h  input  1  shift-in to Q bit 3 on right shift, from the upper slice.
REQ-011 SHALL provide: q_h  output  4  Q register.
REQ-012 SHALL provide: d_h  output  4  D register.
REQ-013 SHALL provide: qshl_out_h  output  1  combinational q_h[3], for the upper slice.
REQ-014 SHALL provide: qshr_out_h  output  1  combinational q_h[0], for the lower slice.
REQ-015 SHALL provide: qsel_err_h  output  1  sticky illegal-select flag.
REQ-016 SHALL provide: qstep_h  output  4  count of Q shifts since the last Q load.
REQ-017 SHALL provide: qpar_h  output  1  registered odd parity of Q.

Function
REQ-018 Q update SHALL occur at a rising clk edge only when qreg_en_h=1 and qmux_onehot_h has exactly one bit set.
REQ-019 Q source select SHALL be:
- wmux: Q <= wmux_h.
- amux: Q <= amux_h.
- shl: Q <= {q[2:0], qshl_in_h}.
- shr: Q <= {qshr_in_h, q[3:1]}.
REQ-020 With qreg_en_h=0, Q SHALL hold and qmux_onehot_h SHALL be ignored; multi-hot and zero-hot select values are legal in this case.
REQ-021 With qreg_en_h=1 and qmux_onehot_h not one-hot (zero or two or more bits set), Q SHALL hold, qstep_h SHALL hold, and qsel_err_h SHALL be set on that edge.
REQ-022 Once set, qsel_err_h SHALL stay 1 until reset.
REQ-023 qstep_h update on an accepted write SHALL be:
- wmux or amux load: clear to 0.
- shl or shr: increment by 1, saturating at 15.
- In every other cycle: hold.
REQ-024 D update SHALL be D <= dbus_h on a rising edge with dreg_en_h=1; otherwise D holds.
REQ-025 D SHALL be fully independent of Q; simultaneous D and Q writes both take effect in the same cycle.
REQ-026 Latency: q_h, d_h, qstep_h, qpar_h and qsel_err_h SHALL change one cycle after the qualifying edge.
REQ-027 qshl_out_h and qshr_out_h SHALL be combinational from the Q register, with zero latency.

Reset
REQ-028 While rst_l=0, regardless of clk:
- q_h=0, d_h=0, qstep_h=0, qsel_err_h=0.
- qpar_h=1 with parity compiled in, 0 without.
REQ-029 Reset asserted mid-shift-sequence SHALL abandon the sequence; the first edge after release SHALL behave as from the reset state.

Configuration
REQ-030 Macro ALP_QDREG_PARITY_EN defined: qpar_h SHALL be a register updated alongside Q with the odd parity of the new Q value (XNOR reduction of Q), and SHALL hold whenever Q holds.
REQ-031 Macro ALP_QDREG_PARITY_EN undefined: the parity register SHALL be absent and qpar_h SHALL be tied to 0; all other behaviour SHALL be unchanged.

Verification
REQ-032 Load then left shift: wmux_h=4'b1001, select wmux, qreg_en_h=1 -> q_h=1001, qstep_h=0, qpar_h=1; then shl with qshl_in_h=1 -> q_h=0011, qshl_out_h=0, qstep_h=1.
REQ-033 Right shift: q_h=1000, select shr, qshr_in_h=1, four cycles -> q_h=1100, 1110, 1111, 1111; qshr_out_h=1 after the third cycle; qstep_h=4.
REQ-034 Illegal select: qreg_en_h=1, qmux_onehot_h=4'b0110 -> q_h holds, qsel_err_h=1, and qsel_err_h stays 1 through later legal writes until rst_l=0.
REQ-035 Disabled multi-hot: qreg_en_h=0, qmux_onehot_h=4'b1111 -> no change to q_h, qstep_h or qsel_err_h; simultaneous dreg_en_h=1 with dbus_h=0xA -> d_h=0xA.
REQ-036 Saturation and reset: 20 consecutive shl cycles -> qstep_h saturates at 15; amux load of 0x5 -> qstep_h=0, q_h=0x5; async rst_l pulse between edges -> all outputs at reset values immediately.

Source files
------------

// File: rtl/alp_qdreg_if.sv
// rtl/alp_qdreg_if.sv - Q/D register slice bus: select, enables, data in, register and cascade outputs
interface alp_qdreg_if;
    logic [3:0] qmux_onehot_h;
    logic       qreg_en_h;
    logic       dreg_en_h;
    logic [3:0] wmux_h;
    logic [3:0] amux_h;
    logic [3:0] dbus_h;
    logic       qshl_in_h;
    logic       qshr_in_h;
    logic [3:0] q_h;
    logic [3:0] d_h;
    logic       qshl_out_h;
    logic       qshr_out_h;
    logic       qsel_err_h;
    logic [3:0] qstep_h;
    logic       qpar_h;

    modport master (
        output qmux_onehot_h, qreg_en_h, dreg_en_h, wmux_h, amux_h, dbus_h,
               qshl_in_h, qshr_in_h,
        input  q_h, d_h, qshl_out_h, qshr_out_h, qsel_err_h, qstep_h, qpar_h
    );

    modport slave (
        input  qmux_onehot_h, qreg_en_h, dreg_en_h, wmux_h, amux_h, dbus_h,
               qshl_in_h, qshr_in_h,
        output q_h, d_h, qshl_out_h, qshr_out_h, qsel_err_h, qstep_h, qpar_h
    );
endinterface

// File: rtl/alp_qdreg.sv
// rtl/alp_qdreg.sv - 4-bit Q/D register slice with shift cascade, step counter, sticky select error; optional parity via ALP_QDREG_PARITY_EN
module alp_qdreg (
    input  logic         clk,
    input  logic         rst_l,
    alp_qdreg_if.slave   bus
);
    localparam logic [3:0] SEL_AMUX = 4'b0001;
    localparam logic [3:0] SEL_SHR  = 4'b0010;
    localparam logic [3:0] SEL_SHL  = 4'b0100;
    localparam logic [3:0] SEL_WMUX = 4'b1000;

    logic [3:0] q_r;
    logic [3:0] d_r;
    logic [3:0] step_r;
    logic       err_r;
    logic [3:0] q_next;
    logic       sel_onehot;
    logic       q_write;
    logic       sel_err;

    // A select is legal only with exactly one bit set; x & (x-1) clears the lowest set bit
    assign sel_onehot = (bus.qmux_onehot_h != 4'b0000) &&
                        ((bus.qmux_onehot_h & (bus.qmux_onehot_h - 4'd1)) == 4'b0000);
    assign q_write    = bus.qreg_en_h && sel_onehot;
    assign sel_err    = bus.qreg_en_h && !sel_onehot;

    // Q source mux; only meaningful when the select is one-hot
    always_comb begin
        q_next = q_r;
        case (bus.qmux_onehot_h)
            SEL_WMUX: q_next = bus.wmux_h;
            SEL_AMUX: q_next = bus.amux_h;
            SEL_SHL:  q_next = {q_r[2:0], bus.qshl_in_h};
            SEL_SHR:  q_next = {bus.qshr_in_h, q_r[3:1]};
            default:  q_next = q_r;
        endcase
    end

    // Q register: loads or shifts only on an accepted write
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            q_r <= 4'd0;
        end else if (q_write) begin
            q_r <= q_next;
        end
    end

    // Shift step counter: loads clear it, shifts count up and stick at 15
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            step_r <= 4'd0;
        end else if (q_write) begin
            if ((bus.qmux_onehot_h == SEL_SHL) || (bus.qmux_onehot_h == SEL_SHR)) begin
                if (step_r != 4'd15) begin
                    step_r <= step_r + 4'd1;
                end
            end else begin
                step_r <= 4'd0;
            end
        end
    end

    // Sticky illegal-select flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            err_r <= 1'b0;
        end else if (sel_err) begin
            err_r <= 1'b1;
        end
    end

    // D register, independent of Q
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            d_r <= 4'd0;
        end else if (bus.dreg_en_h) begin
            d_r <= bus.dbus_h;
        end
    end

`ifdef ALP_QDREG_PARITY_EN
    logic par_r;

    // Odd parity of the value being written into Q; reset matches Q=0
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            par_r <= 1'b1;
        end else if (q_write) begin
            par_r <= ~^q_next;
        end
    end

    assign bus.qpar_h = par_r;
`else
    assign bus.qpar_h = 1'b0;
`endif

    assign bus.q_h        = q_r;
    assign bus.d_h        = d_r;
    assign bus.qstep_h    = step_r;
    assign bus.qsel_err_h = err_r;
    assign bus.qshl_out_h = q_r[3];
    assign bus.qshr_out_h = q_r[0];

endmodule

// File: tb/tb_alp_qdreg.sv
// tb/tb_alp_qdreg.sv - directed and randomized checks of alp_qdreg against a behavioural model
module tb_alp_qdreg;
    logic clk;
    logic rst_l;
    int   checks;
    int   failures;

    int   m_q;
    int   m_d;
    int   m_step;
    int   m_err;

    alp_qdreg_if bus ();

    alp_qdreg dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ones4(input int v);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            n += (v >> i) & 1;
        end
        return n;
    endfunction

    function automatic int exp_par(input int v);
`ifdef ALP_QDREG_PARITY_EN
        return (ones4(v) % 2 == 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"},    int'(bus.q_h),        m_q);
        check({tag, ".d"},    int'(bus.d_h),        m_d);
        check({tag, ".step"}, int'(bus.qstep_h),    m_step);
        check({tag, ".err"},  int'(bus.qsel_err_h), m_err);
        check({tag, ".par"},  int'(bus.qpar_h),     exp_par(m_q));
        check({tag, ".shl_out"}, int'(bus.qshl_out_h), m_q / 8);
        check({tag, ".shr_out"}, int'(bus.qshr_out_h), m_q % 2);
    endtask

    task automatic model_reset();
        m_q = 0;
        m_d = 0;
        m_step = 0;
        m_err = 0;
    endtask

    // Drive one cycle of inputs, advance the model by the rules, wait one edge, compare
    task automatic cycle(input string tag, input logic [3:0] sel, input logic qen,
                         input logic den, input logic [3:0] w, input logic [3:0] a,
                         input logic [3:0] db, input logic shl_in, input logic shr_in);
        int nq;
        int nstep;
        int nerr;
        int nd;
        bus.qmux_onehot_h = sel;
        bus.qreg_en_h     = qen;
        bus.dreg_en_h     = den;
        bus.wmux_h        = w;
        bus.amux_h        = a;
        bus.dbus_h        = db;
        bus.qshl_in_h     = shl_in;
        bus.qshr_in_h     = shr_in;
        nq = m_q;
        nstep = m_step;
        nerr = m_err;
        nd = m_d;
        if (qen) begin
            if (ones4(int'(sel)) == 1) begin
                if (sel[3]) begin
                    nq = int'(w);
                    nstep = 0;
                end else if (sel[0]) begin
                    nq = int'(a);
                    nstep = 0;
                end else if (sel[2]) begin
                    nq = (m_q * 2) % 16 + int'(shl_in);
                    nstep = (m_step < 15) ? m_step + 1 : 15;
                end else begin
                    nq = m_q / 2 + 8 * int'(shr_in);
                    nstep = (m_step < 15) ? m_step + 1 : 15;
                end
            end else begin
                nerr = 1;
            end
        end
        if (den) nd = int'(db);
        @(posedge clk);
        #1;
        m_q = nq;
        m_step = nstep;
        m_err = nerr;
        m_d = nd;
        check_all(tag);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_l = 1'b0;
        bus.qmux_onehot_h = 4'b0000;
        bus.qreg_en_h = 1'b0;
        bus.dreg_en_h = 1'b0;
        bus.wmux_h = 4'd0;
        bus.amux_h = 4'd0;
        bus.dbus_h = 4'd0;
        bus.qshl_in_h = 1'b0;
        bus.qshr_in_h = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset_held");
        rst_l = 1'b1;

        // Load then left shift
        cycle("load_w", 4'b1000, 1, 0, 4'b1001, 4'd0, 4'd0, 0, 0);
        check("load_w.q_const", int'(bus.q_h), 9);
        cycle("shl1", 4'b0100, 1, 0, 4'd0, 4'd0, 4'd0, 1, 0);
        check("shl1.q_const", int'(bus.q_h), 3);
        check("shl1.step_const", int'(bus.qstep_h), 1);

        // Right shift sequence
        cycle("load_8", 4'b1000, 1, 0, 4'b1000, 4'd0, 4'd0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle("shr", 4'b0010, 1, 0, 4'd0, 4'd0, 4'd0, 0, 1);
        end
        check("shr4.q_const", int'(bus.q_h), 15);
        check("shr4.step_const", int'(bus.qstep_h), 4);

        // Disabled multi-hot with a D write
        cycle("dis_mh", 4'b1111, 0, 1, 4'd3, 4'd5, 4'hA, 1, 1);
        check("dis_mh.d_const", int'(bus.d_h), 10);
        cycle("dis_zh", 4'b0000, 0, 0, 4'd3, 4'd5, 4'h1, 0, 0);

        // Illegal select, then legal writes keep the flag
        cycle("illegal", 4'b0110, 1, 0, 4'd2, 4'd4, 4'd0, 1, 1);
        check("illegal.err_const", int'(bus.qsel_err_h), 1);
        cycle("illegal0", 4'b0000, 1, 1, 4'd2, 4'd4, 4'd6, 0, 0);
        cycle("legal_after", 4'b0001, 1, 1, 4'd0, 4'd7, 4'd3, 0, 0);

        // Randomized mix of legal, illegal and disabled writes
        for (int i = 0; i < 300; i++) begin
            logic [3:0] sel;
            int pick;
            pick = int'($urandom_range(0, 9));
            if (pick < 7) sel = 4'b0001 << $urandom_range(0, 3);
            else sel = 4'($urandom);
            cycle("rand", sel, 1'($urandom_range(0, 3) != 0), 1'($urandom),
                  4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
        end

        // Saturation of the step counter
        cycle("pre_sat", 4'b0001, 1, 0, 4'd0, 4'd6, 4'd0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cycle("sat", 4'b0100, 1, 0, 4'd0, 4'd0, 4'd0, 1'($urandom), 0);
        end
        check("sat.step_const", int'(bus.qstep_h), 15);
        cycle("amux5", 4'b0001, 1, 0, 4'd0, 4'h5, 4'd0, 0, 0);
        check("amux5.q_const", int'(bus.q_h), 5);
        check("amux5.step_const", int'(bus.qstep_h), 0);

        // Mid-sequence shifts, then an asynchronous reset pulse between edges
        cycle("mid_shl", 4'b0100, 1, 1, 4'd0, 4'd0, 4'd9, 1, 0);
        cycle("mid_shl2", 4'b0100, 1, 0, 4'd0, 4'd0, 4'd0, 1, 0);
        #2;
        rst_l = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #1;
        rst_l = 1'b1;
        cycle("post_rst_shl", 4'b0100, 1, 0, 4'd0, 4'd0, 4'd0, 1, 0);
        check("post_rst.q_const", int'(bus.q_h), 1);
        check("post_rst.step_const", int'(bus.qstep_h), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
